song_sequencer: RTL and testbench
=================================

# song_sequencer

Parametrised playback controller for the music player: tracks the current song index over `NUM_SONGS` songs and runs play/pause. It handles next/previous navigation and auto-advance on `song_done` according to a play mode. It drives `play`, `song` and a fixed-length `reset_player` pulse into the song player. It replaces the fixed four-song controller and sits between the one-pulsed button inputs and the song player.

## Interface
- `NUM_SONGS`, 4: number of songs, 2..256.
- `SONG_W`, 2: width of `song`; must satisfy 2^SONG_W >= NUM_SONGS.
- `RESET_CYCLES`, 2: length of each `reset_player` pulse in cycles, 1..15.

- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low.
- `play_button` in 1: single-cycle pulse (already debounced and one-pulsed upstream); toggles play/pause.
- `next_button` in 1: single-cycle pulse; advance to the next song.
- `prev_button` in 1: single-cycle pulse; go to the previous song.
- `mode` in 2: playback mode, sampled on each `song_done` edge:
  - 0 = stop after the song
  - 1 = play through to the end of the list, then stop
  - 2 = repeat all
  - 3 = repeat one
- `song_done` in 1: level from the player; the block edge-detects it internally.
- `play` out 1: player enable.
- `reset_player` out 1: player restart pulse.
- `song` out SONG_W: current song index.

## Operation
- Edge detect: `done_edge = song_done & ~done_q`. `done_q` is a register that resets to 0.
- FSM states: STOPPED, PLAYING, PAUSED, SWITCH.
  - `play` = 1 only in PLAYING.
  - `reset_player` = 1 only in SWITCH.
- Reset (`reset`=0 at a clock edge) puts every register in its reset value:
  - state = STOPPED, `song` = 0, `play` = 0, `reset_player` = 0.
  - SWITCH counter = 0, `resume` = 0, `done_q` = 0.
  - Reset during SWITCH aborts the pulse.
- Same-cycle event priority: `next_button` > `prev_button` > `done_edge` > `play_button`. Lower-priority events in that cycle are dropped.
- Index arithmetic:
  - next = (`song` == NUM_SONGS-1) ? 0 : `song`+1.
  - prev = (`song` == 0) ? NUM_SONGS-1 : `song`-1.
  - `song` never holds a value >= NUM_SONGS.
- STOPPED:
  - `play_button` -> PLAYING.
  - next / prev -> update `song`, go to SWITCH with `resume` = 0.
  - `done_edge` is ignored.
- PLAYING:
  - `play_button` -> PAUSED.
  - next / prev -> update `song`, go to SWITCH with `resume` = 1.
  - `done_edge` acts per `mode`:
    - 0: `song` = next, `resume` = 0.
    - 1: if `song` == NUM_SONGS-1 then `song` = 0, `resume` = 0; else `song` = next, `resume` = 1.
    - 2: `song` = next, `resume` = 1.
    - 3: `song` unchanged, `resume` = 1.
    - In every mode, go to SWITCH.
- PAUSED:
  - `play_button` -> PLAYING.
  - next / prev -> update `song`, go to SWITCH with `resume` = 0.
  - `done_edge` is ignored.
- SWITCH:
  - Stays exactly RESET_CYCLES cycles.
  - All button inputs and `done_edge` are dropped while in SWITCH.
  - Exits to PLAYING if `resume` = 1, else to STOPPED.

## Timing
- Input sampled at edge k: `song`, `play` and `reset_player` change after edge k (registered outputs, no combinational path from inputs to outputs).
- `song` updates on the same edge that enters SWITCH, so the new index is stable for the whole `reset_player` pulse.
- `reset_player` is high for exactly RESET_CYCLES consecutive cycles.
- When `resume` = 1, `play` rises on the cycle after `reset_player` falls. `play` is low throughout SWITCH.
- A `song_done` held high produces exactly one `done_edge`. It re-arms only after `song_done` returns low for at least one cycle.

## Configuration
- `SONG_SEQ_SHUFFLE_EN` defined:
  - Adds input port `shuffle` (1 bit).
  - Adds a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advancing every cycle.
  - When `shuffle` = 1, `next_button` and `done_edge` in modes 1 and 2 load `lfsr % NUM_SONGS`. If that equals the current `song`, they load next instead.
  - With `shuffle` = 1, mode 1 behaves as mode 2.
  - `prev_button` and mode 3 are unaffected.
- `SONG_SEQ_SHUFFLE_EN` undefined: no `shuffle` port, no LFSR; sequential ordering only.

## Test plan
All scenarios use NUM_SONGS=4, RESET_CYCLES=2.
1. Hold `reset`=0 for 2 cycles, then release -> `song`=0, `play`=0, `reset_player`=0.
2. From STOPPED, `play_button` -> `play`=1 one cycle later. `play_button` again -> PAUSED, `play`=0. `next_button` -> `song`=1, `reset_player` high 2 cycles, end in STOPPED.
3. PLAYING `song`=3, mode=2, `song_done` held high 5 cycles -> `song`=0, one 2-cycle `reset_player` pulse, `play`=1 afterwards, no second advance.
4. PLAYING `song`=3, mode=1, `song_done` rises -> `song`=0, STOPPED. Same setup with `song`=1 -> `song`=2, PLAYING.
5. `song`=0, `prev_button`=1 and `next_button`=1 in the same cycle -> `song`=1. `prev_button` pulsed during SWITCH is dropped.
6. With `SONG_SEQ_SHUFFLE_EN` defined, `shuffle`=1, PLAYING, 50 `next_button` pulses spaced 5 cycles apart -> `song` always < 4 and never equal to the previous index; sequence identical across two runs.

Source files
------------

// File: rtl/song_sequencer_if.sv
// ---------------------------------------------------------------------------
// song_sequencer_if
//   Bundles the signals between the button/player side and song_sequencer.
//   master : drives buttons, mode and song_done; observes the player controls.
//   slave  : the sequencer; samples the controls and drives play,
//            reset_player and song.
//   SONG_W : width of the song index.
// ---------------------------------------------------------------------------
interface song_sequencer_if #(
    parameter int SONG_W = 2
);
    logic              play_button;
    logic              next_button;
    logic              prev_button;
    logic [1:0]        mode;
    logic              song_done;
    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] song;

    modport master (
        output play_button, next_button, prev_button, mode, song_done,
        input  play, reset_player, song
    );

    modport slave (
        input  play_button, next_button, prev_button, mode, song_done,
        output play, reset_player, song
    );
endinterface

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
//   Playback controller for the music player. Tracks the current song index
//   over NUM_SONGS songs, runs play/pause, handles next/previous navigation
//   and auto-advance on song_done according to the play mode, and issues a
//   fixed-length reset_player pulse whenever the song changes or restarts.
//
// Parameters
//   NUM_SONGS    : number of songs (2..256)
//   SONG_W       : width of song, 2**SONG_W >= NUM_SONGS
//   RESET_CYCLES : reset_player pulse length in cycles (1..15)
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   reset   : synchronous, active-low
//   shuffle : (SONG_SEQ_SHUFFLE_EN only) random next-song selection
//   bus     : song_sequencer_if.slave
//             in  play_button, next_button, prev_button (one-cycle pulses),
//                 mode[1:0], song_done (level)
//             out play, reset_player, song[SONG_W-1:0] (all register-decoded)
//
// Optional feature macro: SONG_SEQ_SHUFFLE_EN adds the shuffle port and a
// 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1).
// ---------------------------------------------------------------------------
module song_sequencer #(
    parameter int NUM_SONGS    = 4,
    parameter int SONG_W       = 2,
    parameter int RESET_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
`ifdef SONG_SEQ_SHUFFLE_EN
    input  logic            shuffle,
`endif
    song_sequencer_if.slave bus
);
    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_SWITCH  = 2'd3;

    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
    localparam logic [3:0]        CNT_LAST  = 4'(RESET_CYCLES - 1);

    logic [1:0]        state_reg,  state_next;
    logic [SONG_W-1:0] song_reg,   song_next;
    logic [3:0]        cnt_reg,    cnt_next;
    logic              resume_reg, resume_next;
    logic              done_q_reg;

    logic              done_edge;
    logic [SONG_W-1:0] seq_next;    // sequential successor
    logic [SONG_W-1:0] seq_prev;    // sequential predecessor
    logic [SONG_W-1:0] next_sel;    // successor used by next_button / modes 1,2
    logic              mode1_wraps; // mode 1 treated as repeat-all

    assign done_edge = bus.song_done & ~done_q_reg;
    assign seq_next  = (song_reg == LAST_SONG) ? '0 : song_reg + 1'b1;
    assign seq_prev  = (song_reg == '0) ? LAST_SONG : song_reg - 1'b1;

`ifdef SONG_SEQ_SHUFFLE_EN
    logic [15:0]       lfsr_reg;
    logic              lfsr_fb;
    logic [SONG_W-1:0] shuf_idx;

    assign lfsr_fb  = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
    assign shuf_idx = SONG_W'(lfsr_reg % 16'(NUM_SONGS));
    // A random pick equal to the current song falls back to the successor so
    // that "next" always changes the song.
    assign next_sel    = (shuffle && (shuf_idx != song_reg)) ? shuf_idx : seq_next;
    assign mode1_wraps = shuffle;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
        end
    end
`else
    assign next_sel    = seq_next;
    assign mode1_wraps = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        song_next   = song_reg;
        cnt_next    = cnt_reg;
        resume_next = resume_reg;

        case (state_reg)
            ST_SWITCH: begin
                // Every input is dropped here; only the pulse timer runs.
                if (cnt_reg == CNT_LAST) begin
                    state_next = resume_reg ? ST_PLAYING : ST_STOPPED;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_PLAYING: begin
                if (bus.next_button) begin
                    song_next   = next_sel;
                    resume_next = 1'b1;
                    state_next  = ST_SWITCH;
                    cnt_next    = 4'd0;
                end else if (bus.prev_button) begin
                    song_next   = seq_prev;
                    resume_next = 1'b1;
                    state_next  = ST_SWITCH;
                    cnt_next    = 4'd0;
                end else if (done_edge) begin
                    state_next = ST_SWITCH;
                    cnt_next   = 4'd0;
                    case (bus.mode)
                        2'd0: begin
                            song_next   = seq_next;
                            resume_next = 1'b0;
                        end
                        2'd1: begin
                            if (mode1_wraps) begin
                                song_next   = next_sel;
                                resume_next = 1'b1;
                            end else if (song_reg == LAST_SONG) begin
                                song_next   = '0;
                                resume_next = 1'b0;
                            end else begin
                                song_next   = seq_next;
                                resume_next = 1'b1;
                            end
                        end
                        2'd2: begin
                            song_next   = next_sel;
                            resume_next = 1'b1;
                        end
                        default: begin
                            resume_next = 1'b1;
                        end
                    endcase
                end else if (bus.play_button) begin
                    state_next = ST_PAUSED;
                end
            end
            default: begin
                // STOPPED and PAUSED behave alike; song_done is ignored.
                if (bus.next_button) begin
                    song_next   = next_sel;
                    resume_next = 1'b0;
                    state_next  = ST_SWITCH;
                    cnt_next    = 4'd0;
                end else if (bus.prev_button) begin
                    song_next   = seq_prev;
                    resume_next = 1'b0;
                    state_next  = ST_SWITCH;
                    cnt_next    = 4'd0;
                end else if (bus.play_button) begin
                    state_next = ST_PLAYING;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_STOPPED;
            song_reg   <= '0;
            cnt_reg    <= 4'd0;
            resume_reg <= 1'b0;
            done_q_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            song_reg   <= song_next;
            cnt_reg    <= cnt_next;
            resume_reg <= resume_next;
            done_q_reg <= bus.song_done;
        end
    end

    // Outputs are decoded from registers only.
    assign bus.play         = (state_reg == ST_PLAYING);
    assign bus.reset_player = (state_reg == ST_SWITCH);
    assign bus.song         = song_reg;
endmodule

// File: tb/tb_song_sequencer.sv
// ---------------------------------------------------------------------------
// tb_song_sequencer
//   Directed bench for song_sequencer with NUM_SONGS=4, RESET_CYCLES=2.
//   Inputs change and outputs are checked on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_song_sequencer;
    localparam int P_PLAY = 0;
    localparam int P_NEXT = 1;
    localparam int P_PREV = 2;
    localparam int P_DONE = 3;
    localparam int P_BOTH = 4;

    logic clk;
    logic reset;
`ifdef SONG_SEQ_SHUFFLE_EN
    logic shuffle;
    int   seq_a [50];
`endif
    int tests_run;
    int tests_failed;

    song_sequencer_if #(.SONG_W(2)) bus ();

    song_sequencer #(
        .NUM_SONGS   (4),
        .SONG_W      (2),
        .RESET_CYCLES(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef SONG_SEQ_SHUFFLE_EN
        .shuffle(shuffle),
`endif
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at a falling edge; the input is sampled on the next rising edge
    // and the task returns at the falling edge after it.
    task automatic press(input int which);
        case (which)
            P_PLAY:  bus.play_button = 1'b1;
            P_NEXT:  bus.next_button = 1'b1;
            P_PREV:  bus.prev_button = 1'b1;
            P_DONE:  bus.song_done   = 1'b1;
            default: begin
                bus.next_button = 1'b1;
                bus.prev_button = 1'b1;
            end
        endcase
        step();
        bus.play_button = 1'b0;
        bus.next_button = 1'b0;
        bus.prev_button = 1'b0;
        bus.song_done   = 1'b0;
        $display("[TB] t=%0t event %0d -> song=%0d play=%0b reset_player=%0b",
                 $time, which, bus.song, bus.play, bus.reset_player);
    endtask

    // Wait out the remaining SWITCH cycles after the entering edge.
    task automatic wait_switch();
        step();
        step();
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b0;
        bus.play_button = 1'b0;
        bus.next_button = 1'b0;
        bus.prev_button = 1'b0;
        bus.song_done   = 1'b0;
        bus.mode        = 2'd0;
`ifdef SONG_SEQ_SHUFFLE_EN
        shuffle = 1'b0;
`endif
        // 1. reset
        step();
        step();
        check("rst_song", 32'(bus.song), 0);
        check("rst_play", 32'(bus.play), 0);
        check("rst_rp",   32'(bus.reset_player), 0);
        reset = 1'b1;
        step();
        check("idle_play", 32'(bus.play), 0);

        // 2. play, pause, next from PAUSED -> STOPPED
        press(P_PLAY);
        check("play_on", 32'(bus.play), 1);
        press(P_PLAY);
        check("pause_off", 32'(bus.play), 0);
        press(P_NEXT);
        check("pn_song", 32'(bus.song), 1);
        check("pn_rp1",  32'(bus.reset_player), 1);
        check("pn_play", 32'(bus.play), 0);
        step();
        check("pn_rp2",  32'(bus.reset_player), 1);
        step();
        check("pn_rp_end", 32'(bus.reset_player), 0);
        check("pn_stopped", 32'(bus.play), 0);
        press(P_PLAY);
        check("resume_play", 32'(bus.play), 1);
        press(P_NEXT);
        check("nx2_song", 32'(bus.song), 2);
        wait_switch();
        check("nx2_play", 32'(bus.play), 1);
        press(P_NEXT);
        wait_switch();
        check("nx3_song", 32'(bus.song), 3);

        // 3. mode 2, song_done held five cycles
        bus.mode      = 2'd2;
        bus.song_done = 1'b1;
        step();
        check("m2_song", 32'(bus.song), 0);
        check("m2_rp1",  32'(bus.reset_player), 1);
        check("m2_play_sw", 32'(bus.play), 0);
        step();
        check("m2_rp2",  32'(bus.reset_player), 1);
        step();
        check("m2_rp_end", 32'(bus.reset_player), 0);
        check("m2_play", 32'(bus.play), 1);
        step();
        step();
        check("m2_hold_song", 32'(bus.song), 0);
        check("m2_hold_rp",   32'(bus.reset_player), 0);
        bus.song_done = 1'b0;
        step();

        // 4. mode 1 at the end of the list, then in the middle
        press(P_PREV);
        check("prev_wrap", 32'(bus.song), 3);
        wait_switch();
        check("prev_play", 32'(bus.play), 1);
        bus.mode = 2'd1;
        press(P_DONE);
        check("m1_end_song", 32'(bus.song), 0);
        check("m1_end_rp", 32'(bus.reset_player), 1);
        wait_switch();
        check("m1_end_stop", 32'(bus.play), 0);
        press(P_PLAY);
        press(P_NEXT);
        wait_switch();
        press(P_DONE);
        check("m1_mid_song", 32'(bus.song), 2);
        wait_switch();
        check("m1_mid_play", 32'(bus.play), 1);

        // song_done ignored while paused
        press(P_PLAY);
        check("pause2", 32'(bus.play), 0);
        press(P_DONE);
        check("pause_done_song", 32'(bus.song), 2);
        check("pause_done_rp", 32'(bus.reset_player), 0);
        press(P_PLAY);

        // mode 3 repeats, mode 0 advances and stops
        bus.mode = 2'd3;
        press(P_DONE);
        check("m3_song", 32'(bus.song), 2);
        check("m3_rp", 32'(bus.reset_player), 1);
        wait_switch();
        check("m3_play", 32'(bus.play), 1);
        bus.mode = 2'd0;
        press(P_DONE);
        check("m0_song", 32'(bus.song), 3);
        wait_switch();
        check("m0_stop", 32'(bus.play), 0);

        // 5. next beats prev; prev during SWITCH dropped
        press(P_NEXT);
        wait_switch();
        check("to0_song", 32'(bus.song), 0);
        press(P_PLAY);
        press(P_BOTH);
        check("both_song", 32'(bus.song), 1);
        check("both_rp", 32'(bus.reset_player), 1);
        press(P_PREV);
        check("sw_prev_rp", 32'(bus.reset_player), 1);
        check("sw_prev_song", 32'(bus.song), 1);
        step();
        check("sw_exit_song", 32'(bus.song), 1);
        check("sw_exit_play", 32'(bus.play), 1);

        // reset during SWITCH aborts the pulse
        press(P_NEXT);
        check("abort_pre", 32'(bus.reset_player), 1);
        reset = 1'b0;
        step();
        check("abort_rp", 32'(bus.reset_player), 0);
        check("abort_song", 32'(bus.song), 0);
        reset = 1'b1;
        step();

`ifdef SONG_SEQ_SHUFFLE_EN
        // 6. shuffle: two identical runs
        for (int run = 0; run < 2; run++) begin
            int prev_idx;
            reset   = 1'b0;
            shuffle = 1'b1;
            step();
            reset = 1'b1;
            step();
            press(P_PLAY);
            prev_idx = 0;
            for (int i = 0; i < 50; i++) begin
                press(P_NEXT);
                check("shuf_range", 32'(bus.song < 2'd3 || bus.song == 2'd3), 1);
                check("shuf_change", 32'(int'(bus.song) != prev_idx), 1);
                if (run == 0) begin
                    seq_a[i] = int'(bus.song);
                end else begin
                    check("shuf_repeat", 32'(bus.song), 32'(seq_a[i]));
                end
                prev_idx = int'(bus.song);
                for (int k = 0; k < 4; k++) step();
            end
        end
        shuffle = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
